seven_seg_capture: RTL and testbench

Receive-side counterpart of the seven-segment hex encoder: it samples a multiplexed, active-low seven-segment bus (segment lines plus digit anode selects), waits for each digit's pattern to settle, and decodes it back to a nybble. Once all four digits have been captured, it reassembles them into a 16-bit word. It is used in loopback test harnesses and display-readback paths to confirm that the value driven to the display matches the value intended.

---
 rtl/seven_seg_capture.sv | 93 +++++++++
 tb/tb_seven_seg_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples a multiplexed active-low seven-segment bus, debounces each digit,
// decodes it back to a nybble and reassembles the four digits into a 16-bit word.
module seven_seg_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] word,
   output logic        valid,
   output logic        error,
   output logic [1:0]  err_digit
);
   logic [11:0] prev;
   logic [3:0]  cnt;
   logic [3:0]  captured;
   logic [15:0] shadow;
   logic [3:0]  sel;
   logic        onehot;
   logic        stable;
   logic        accept;
   logic [1:0]  idx;
   logic        code_ok;
   logic [3:0]  nyb;
   logic [3:0]  cap_next;
   logic [15:0] merged;

   always_comb begin
      sel      = ~an;
      onehot   = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
      stable   = onehot && ({an, seg} == prev);
      accept   = stable && (cnt == 4'(STABLE_CYCLES - 2));
      idx      = sel[1] ? 2'd1 : sel[2] ? 2'd2 : sel[3] ? 2'd3 : 2'd0;
      code_ok  = 1'b1;
      nyb      = 4'h0;
      // dp (seg[7]) plays no part in the decoded value
      case (seg[6:0])
         7'h40: nyb = 4'h0;
         7'h79: nyb = 4'h1;
         7'h24: nyb = 4'h2;
         7'h30: nyb = 4'h3;
         7'h19: nyb = 4'h4;
         7'h12: nyb = 4'h5;
         7'h02: nyb = 4'h6;
         7'h78: nyb = 4'h7;
         7'h00: nyb = 4'h8;
         7'h10: nyb = 4'h9;
         7'h08: nyb = 4'hA;
         7'h03: nyb = 4'hB;
         7'h46: nyb = 4'hC;
         7'h21: nyb = 4'hD;
         7'h06: nyb = 4'hE;
         7'h0E: nyb = 4'hF;
         default: code_ok = 1'b0;
      endcase
      merged                  = shadow;
      merged[{idx, 2'b00} +: 4] = nyb;
      cap_next                = captured | (4'b0001 << idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev      <= 12'hFFF;
         cnt       <= 4'd0;
         captured  <= 4'd0;
         shadow    <= 16'h0;
         word      <= 16'h0;
         valid     <= 1'b0;
         error     <= 1'b0;
         err_digit <= 2'd0;
      end else begin
         prev  <= {an, seg};
         cnt   <= !stable ? 4'd0 : (cnt == 4'(STABLE_CYCLES - 1)) ? cnt : cnt + 4'd1;
         valid <= 1'b0;
         error <= 1'b0;
         if (accept && code_ok) begin
            shadow <= merged;
            if (cap_next == 4'hF) begin
               word     <= merged;
               valid    <= 1'b1;
               captured <= 4'd0;
            end else begin
               captured <= cap_next;
            end
         end else if (accept) begin
            error          <= 1'b1;
            err_digit      <= idx;
            captured[idx]  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: scoreboard bench; expected word/error events are queued as digits are
// driven and popped when the DUT pulses valid or error.
module tb_seven_seg_capture;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  seg = 8'hFF;
   logic [3:0]  an  = 4'hF;
   logic [15:0] word;
   logic        valid;
   logic        error;
   logic [1:0]  err_digit;

   int asserts = 0;
   int fails   = 0;

   logic [18:0] sb[$];
   logic [3:0]  m_cap = 4'd0;
   logic [15:0] m_shd = 16'h0;
   logic [7:0]  codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seven_seg_capture #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .seg(seg), .an(an),
      .word(word), .valid(valid), .error(error), .err_digit(err_digit)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] dec(input logic [7:0] s);
      for (int k = 0; k < 16; k++)
         if (codes[k][6:0] == s[6:0]) return {1'b1, 4'(k)};
      return 5'd0;
   endfunction

   // Entry layout: {is_error, err_digit, word}
   always @(negedge clk) begin
      if (valid || error) begin
         logic [18:0] exp_v;
         logic [18:0] got;
         asserts++;
         got = {error, error ? err_digit : 2'd0, valid ? word : 16'h0};
         if (valid && error) begin
            fails++;
            $display("FAIL valid_and_error both high word=%h err_digit=%0d", word, err_digit);
         end else if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event got valid=%b error=%b word=%h err_digit=%0d required none",
                     valid, error, word, err_digit);
         end else begin
            exp_v = sb.pop_front();
            if (got !== exp_v) begin
               fails++;
               $display("FAIL event got err=%b digit=%0d word=%h required err=%b digit=%0d word=%h",
                        got[18], got[17:16], got[15:0], exp_v[18], exp_v[17:16], exp_v[15:0]);
            end
         end
      end
   end

   task automatic drive(input logic [3:0] a, input logic [7:0] s, input int h);
      logic [4:0] d;
      int i;
      an  = a;
      seg = s;
      if ($countones(~a) == 1 && h >= S) begin
         i = 0;
         for (int k = 0; k < 4; k++) if (!a[k]) i = k;
         d = dec(s);
         if (d[4]) begin
            m_shd[i*4 +: 4] = d[3:0];
            m_cap[i] = 1'b1;
            if (m_cap == 4'hF) begin
               sb.push_back({3'b000, m_shd});
               m_cap = 4'd0;
            end
         end else begin
            sb.push_back({1'b1, 2'(i), 16'h0});
            m_cap[i] = 1'b0;
         end
      end
      repeat (h) @(negedge clk);
   endtask

   task automatic drain(input string name);
      drive(4'hF, 8'hFF, 3);
      asserts++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s pending_events got %0d required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      asserts++;
      if ({word, valid, error, err_digit} !== 20'h0) begin
         fails++;
         $display("FAIL reset_outputs got word=%h valid=%b error=%b err_digit=%0d required all 0",
                  word, valid, error, err_digit);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clean_scan();
      drive(4'hE, 8'h8E, 4);
      drive(4'hD, 8'hB0, 4);
      drive(4'hB, 8'h88, 4);
      asserts++;
      if (valid !== 1'b0) begin
         fails++;
         $display("FAIL clean_scan_early_valid got %b required 0", valid);
      end
      drive(4'h7, 8'hF9, 4);
      asserts++;
      if (valid !== 1'b1 || word !== 16'h1A3F) begin
         fails++;
         $display("FAIL clean_scan_latency got valid=%b word=%h required valid=1 word=1a3f", valid, word);
      end
      drive(4'hF, 8'hFF, 1);
      asserts++;
      if (valid !== 1'b0) begin
         fails++;
         $display("FAIL clean_scan_pulse_width got valid=%b required 0", valid);
      end
      drain("clean_scan");
   endtask

   task automatic test_glitch();
      drive(4'hE, 8'hC6, 4);
      drive(4'hD, 8'h99, 4);
      drive(4'hB, 8'h82, 2);
      drive(4'hB, 8'hA4, 4);
      drive(4'h7, 8'h86, 4);
      asserts++;
      if (word[11:8] !== 4'h2) begin
         fails++;
         $display("FAIL glitch_nybble got %h required 2", word[11:8]);
      end
      drain("glitch");
   endtask

   task automatic test_undecodable();
      drive(4'hE, 8'h80, 4);
      drive(4'hD, 8'hFF, 4);
      asserts++;
      if (error !== 1'b1 || err_digit !== 2'd1) begin
         fails++;
         $display("FAIL undecodable got error=%b err_digit=%0d required error=1 err_digit=1", error, err_digit);
      end
      drive(4'hB, 8'hA1, 4);
      drive(4'h7, 8'hF8, 4);
      drive(4'hD, 8'h92, 4);
      drain("undecodable");
   endtask

   task automatic test_invalid_selects();
      drive(4'hE, 8'h83, 4);
      drive(4'hD, 8'hC0, 4);
      drive(4'h3, 8'hF9, 20);
      drive(4'hF, 8'h00, 20);
      drive(4'hB, 8'hF8, 4);
      drive(4'h7, 8'h90, 4);
      drain("invalid_selects");
   endtask

   task automatic test_reset_mid_set();
      drive(4'hE, 8'hB0, 4);
      drive(4'hD, 8'hB0, 4);
      drive(4'hB, 8'hB0, 4);
      an  = 4'hF;
      seg = 8'hFF;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_cap = 4'd0;
      m_shd = 16'h0;
      asserts++;
      if ({word, valid, error, err_digit} !== 20'h0) begin
         fails++;
         $display("FAIL reset_mid_set got word=%h valid=%b error=%b err_digit=%0d required all 0",
                  word, valid, error, err_digit);
      end
      drive(4'h7, 8'h99, 4);
      drain("reset_mid_set");
   endtask

   task automatic test_long_hold();
      drive(4'hE, 8'h90, 20);
      drive(4'hE, 8'h10, 1);
      drive(4'hE, 8'h90, 29);
      drive(4'hD, 8'h88, 4);
      drive(4'hB, 8'h92, 4);
      asserts++;
      if (word !== 16'h45A9) begin
         fails++;
         $display("FAIL long_hold_word got %h required 45a9", word);
      end
      drain("long_hold");
   endtask

   initial begin
      test_reset();
      test_clean_scan();
      test_glitch();
      test_undecodable();
      test_invalid_selects();
      test_reset_mid_set();
      test_long_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
